// File: rtl/jpeg_idct_transpose_buffer.sv
// jpeg_idct_transpose_buffer
//
// Ping-pong transpose buffer between the IDCT row and column passes. A BLOCK_N x BLOCK_N
// block arrives in row-major order on the input stream, is stored in one of two banks,
// and is replayed in column-major order on the output stream. One bank fills while the
// other drains, so both streams can sustain one word per cycle.
//
// Optional feature: define JPEG_IDCT_TRANSPOSE_FLUSH_EN to add the flush_i port, which
// clears all state like reset and overrides any handshake in the same cycle.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   flush_i      (JPEG_IDCT_TRANSPOSE_FLUSH_EN only) discard all buffered data
//   in_valid_i   input word valid
//   in_data_i    input word, row-major order
//   in_ready_o   buffer accepts in_data_i this cycle
//   out_valid_o  output word valid
//   out_data_o   output word, column-major order
//   out_ready_i  downstream accepts out_data_o this cycle
//   level_o      number of banks currently marked full (0..2)

module jpeg_idct_transpose_buffer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BLOCK_N = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  input  logic              flush_i,
`endif
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic [1:0]        level_o
);

  localparam int unsigned Words = BLOCK_N * BLOCK_N;
  localparam int unsigned HalfW = $clog2(BLOCK_N);
  localparam int unsigned IdxW  = 2 * HalfW;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Words - 1);

  // Storage: bank select is the address MSB.
  logic [DATA_W-1:0] mem_q [2*Words];
  logic [DATA_W-1:0] rd_data_q;

  // Write side
  logic            wr_bank_q, wr_bank_d;
  logic [IdxW-1:0] wr_idx_q, wr_idx_d;
  logic            wr_en;
  logic [IdxW:0]   wr_addr;

  // Read side
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_idx_q, rd_idx_d;
  logic            rd_en;
  logic [IdxW:0]   rd_addr;
  logic            rd_vld_q, rd_vld_d;

  logic [1:0]      full_q, full_d;

  // Two-entry output skid FIFO
  logic [DATA_W-1:0] fifo_q [2];
  logic              fifo_wr_ptr_q, fifo_wr_ptr_d;
  logic              fifo_rd_ptr_q, fifo_rd_ptr_d;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;
  logic              push, pop;
  logic [2:0]        credit_used;

  logic clr;

`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  assign clr = !rst_i || flush_i;
`else
  assign clr = !rst_i;
`endif

  always_comb begin
    in_ready_o  = !full_q[wr_bank_q];
    wr_en       = in_valid_i && in_ready_o;
    wr_addr     = {wr_bank_q, wr_idx_q};

    out_valid_o = (fifo_cnt_q != 2'd0);
    out_data_o  = fifo_q[fifo_rd_ptr_q];
    pop         = out_valid_o && out_ready_i;
    push        = rd_vld_q;

    // Occupancy is counted after this cycle's pop so a steady drain keeps issuing one
    // read per cycle; the word in the read register counts as in flight.
    credit_used = 3'(fifo_cnt_q) - 3'(pop) + 3'(rd_vld_q);
    rd_en       = full_q[rd_bank_q] && (credit_used < 3'd2);

    // Swapping the index halves turns row-major storage into column-major replay.
    rd_addr     = {rd_bank_q, rd_idx_q[HalfW-1:0], rd_idx_q[IdxW-1:HalfW]};

    level_o     = 2'(full_q[0]) + 2'(full_q[1]);
  end

  always_comb begin
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    rd_bank_d     = rd_bank_q;
    rd_idx_d      = rd_idx_q;
    full_d        = full_q;
    rd_vld_d      = rd_en;
    fifo_wr_ptr_d = fifo_wr_ptr_q;
    fifo_rd_ptr_d = fifo_rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q + 2'(push) - 2'(pop);

    if (wr_en) begin
      // Index wraps to zero naturally: Words is a power of two.
      wr_idx_d = wr_idx_q + 1'b1;
      if (wr_idx_q == LastIdx) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
      end
    end

    // A read bank is always full and a write bank never is, so these never collide.
    if (rd_en) begin
      rd_idx_d = rd_idx_q + 1'b1;
      if (rd_idx_q == LastIdx) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
      end
    end

    if (push) fifo_wr_ptr_d = !fifo_wr_ptr_q;
    if (pop)  fifo_rd_ptr_d = !fifo_rd_ptr_q;
  end

  always_ff @(posedge clk_i) begin
    if (clr) begin
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      rd_bank_q     <= 1'b0;
      rd_idx_q      <= '0;
      full_q        <= 2'b00;
      rd_vld_q      <= 1'b0;
      fifo_wr_ptr_q <= 1'b0;
      fifo_rd_ptr_q <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      rd_bank_q     <= rd_bank_d;
      rd_idx_q      <= rd_idx_d;
      full_q        <= full_d;
      rd_vld_q      <= rd_vld_d;
      fifo_wr_ptr_q <= fifo_wr_ptr_d;
      fifo_rd_ptr_q <= fifo_rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      if (push) fifo_q[fifo_wr_ptr_q] <= rd_data_q;
    end
  end

  // Storage array and read register carry no reset; their contents are only consumed
  // through the reset-controlled flags above.
  always_ff @(posedge clk_i) begin
    if (wr_en && !clr) mem_q[wr_addr] <= in_data_i;
    if (rd_en)         rd_data_q      <= mem_q[rd_addr];
  end

endmodule
